// File: rtl/core_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Read hits answer in one cycle; read misses refill a 4-word line.
module core_cache_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_AW   = 8,
  parameter int TAG_WIDTH  = 20,
  parameter int OFFSET_AW  = 4,
  parameter int RAM_NUM    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_req_i,
  input  logic                  cache_op_i,
  input  logic [INDEX_AW-1:0]   cache_index_i,
  input  logic [TAG_WIDTH-1:0]  cache_tag_i,
  input  logic [OFFSET_AW-1:0]  cache_offset_i,
  input  logic [RAM_NUM-1:0]    cache_wr_en_i,
  input  logic [DATA_WIDTH-1:0] cache_wr_data_i,
  output logic [DATA_WIDTH-1:0] cache_rd_data_o,
  output logic                  cache_addr_ack_o,
  output logic                  cache_data_ack_o,
  output logic                  mem_rd_req_o,
  output logic                  mem_wr_req_o,
  output logic [TAG_WIDTH+INDEX_AW+OFFSET_AW-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic [RAM_NUM-1:0]    mem_wr_strb_o,
  input  logic                  mem_rd_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  input  logic                  mem_wr_ack_i
);
  localparam int LINES = 1 << INDEX_AW;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS, REFILL, WRMEM, RESP
  } state_t;

  state_t state, state_n;

  logic                  req_op;
  logic [INDEX_AW-1:0]   req_index;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [OFFSET_AW-1:0]  req_offset;
  logic [RAM_NUM-1:0]    req_wr_en;
  logic [DATA_WIDTH-1:0] req_wr_data;

  logic [LINES-1:0]      valid;
  logic [TAG_WIDTH-1:0]  tag_arr [LINES];
  logic [DATA_WIDTH-1:0] data_arr [LINES][4];

  logic [1:0]            beat;
  logic [1:0]            fill_word;
  logic [1:0]            word_sel;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  hit, rd_hit, wr_hit;
  logic                  capture, fill, last_beat;

  assign word_sel  = req_offset[3:2];
  assign hit       = valid[req_index] &&
                     (tag_arr[req_index] == req_tag);
  assign rd_hit    = (state == LOOKUP) && !req_op && hit;
  assign wr_hit    = (state == LOOKUP) && req_op && hit;
  assign fill      = mem_rd_valid_i &&
                     ((state == MISS) || (state == REFILL));
  assign fill_word = (state == MISS) ? 2'd0 : beat;
  assign last_beat = fill && (state == REFILL) &&
                     (beat == 2'd3);

  assign cache_addr_ack_o = !rst &&
    ((state == IDLE) || rd_hit);
  assign cache_data_ack_o = !rst &&
    (rd_hit || (state == RESP));
  assign cache_rd_data_o = rst ? '0 :
    rd_hit ? data_arr[req_index][word_sel] : rd_q;
  assign capture = cache_req_i && cache_addr_ack_o;

  always_comb begin
    merged = data_arr[req_index][word_sel];
    for (int b = 0; b < RAM_NUM; b++) begin
      if (req_wr_en[b])
        merged[b*8 +: 8] = req_wr_data[b*8 +: 8];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (cache_req_i) state_n = LOOKUP;
      LOOKUP: begin
        if (req_op)        state_n = WRMEM;
        else if (!hit)     state_n = MISS;
        else if (capture)  state_n = LOOKUP;
        else               state_n = IDLE;
      end
      MISS:   if (mem_rd_valid_i) state_n = REFILL;
      REFILL: if (last_beat) state_n = RESP;
      WRMEM:  if (mem_wr_ack_i) state_n = RESP;
      RESP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      req_op        <= 1'b0;
      req_index     <= '0;
      req_tag       <= '0;
      req_offset    <= '0;
      req_wr_en     <= '0;
      req_wr_data   <= '0;
      beat          <= 2'd0;
      rd_q          <= '0;
      mem_rd_req_o  <= 1'b0;
      mem_wr_req_o  <= 1'b0;
      mem_addr_o    <= '0;
      mem_wr_data_o <= '0;
      mem_wr_strb_o <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        req_op      <= cache_op_i;
        req_index   <= cache_index_i;
        req_tag     <= cache_tag_i;
        req_offset  <= cache_offset_i;
        req_wr_en   <= cache_wr_en_i;
        req_wr_data <= cache_wr_data_i;
      end
      if (rd_hit)
        rd_q <= data_arr[req_index][word_sel];
      if (fill) begin
        beat <= fill_word + 2'd1;
        if (fill_word == word_sel) rd_q <= mem_rd_data_i;
      end
      // Line stays invalid for the whole fetch so an abort leaves no stale data
      if (state == MISS) valid[req_index] <= 1'b0;
      if (last_beat)     valid[req_index] <= 1'b1;
      mem_rd_req_o  <= (state_n == MISS);
      mem_wr_req_o  <= (state_n == WRMEM);
      mem_addr_o    <= '0;
      mem_wr_data_o <= '0;
      mem_wr_strb_o <= '0;
      if (state_n == MISS)
        mem_addr_o <= {req_tag, req_index,
                       {OFFSET_AW{1'b0}}};
      if (state_n == WRMEM) begin
        mem_addr_o    <= {req_tag, req_index, req_offset};
        mem_wr_data_o <= req_wr_data;
        mem_wr_strb_o <= req_wr_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill)
      data_arr[req_index][fill_word] <= mem_rd_data_i;
    if (last_beat)
      tag_arr[req_index] <= req_tag;
    if (wr_hit)
      data_arr[req_index][word_sel] <= merged;
  end

endmodule

// File: tb/tb_core_cache_ctrl.sv
// Directed bench for core_cache_ctrl: memory model plus
// a scoreboard of expected completions.
module tb_core_cache_ctrl;
  localparam int RLAT = 2;
  localparam int WLAT = 1;

  logic        clk, rst;
  logic        cache_req, cache_op;
  logic [7:0]  cache_index;
  logic [19:0] cache_tag;
  logic [3:0]  cache_offset, cache_wr_en;
  logic [31:0] cache_wr_data, cache_rd_data;
  logic        cache_addr_ack, cache_data_ack;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_addr32;
  logic [27:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        mem_rd_valid, mem_wr_ack;
  logic [31:0] mem_rd_data;

  core_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cache_req_i(cache_req), .cache_op_i(cache_op),
    .cache_index_i(cache_index), .cache_tag_i(cache_tag),
    .cache_offset_i(cache_offset),
    .cache_wr_en_i(cache_wr_en),
    .cache_wr_data_i(cache_wr_data),
    .cache_rd_data_o(cache_rd_data),
    .cache_addr_ack_o(cache_addr_ack),
    .cache_data_ack_o(cache_data_ack),
    .mem_rd_req_o(mem_rd_req), .mem_wr_req_o(mem_wr_req),
    .mem_addr_o(mem_addr),
    .mem_wr_data_o(mem_wr_data),
    .mem_wr_strb_o(mem_wr_strb),
    .mem_rd_valid_i(mem_rd_valid),
    .mem_rd_data_i(mem_rd_data),
    .mem_wr_ack_i(mem_wr_ack)
  );

  assign mem_addr32 = {4'h0, mem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory image: writes merge in, untouched words have a
  // fixed pattern
  logic [31:0] mem [int];

  function automatic logic [31:0] rd_word(input logic [27:0] a);
    int k;
    k = int'({a[27:2], 2'b00});
    if (mem.exists(k)) return mem[k];
    if (a[27:4] == 24'h000123) return 32'hA0 + 32'(a[3:2]);
    return {4'h0, a[27:2], 2'b00};
  endfunction

  int rd_wait = -1;
  int rd_beat = 0;
  int wr_wait = 0;
  int fetch_cnt = 0;
  int wr_cnt = 0;
  int f_cyc = 0;
  int a_cyc = 0;
  logic [27:0] rd_line, fetch_addr, wr_addr;
  logic [31:0] wr_dat, merged;
  logic [3:0]  wr_strb;

  always @(negedge clk) begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    mem_wr_ack   = 1'b0;
    if (rst) begin
      rd_wait = -1;
      wr_wait = 0;
    end else begin
      if (rd_wait == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data = rd_word({rd_line[27:4], 2'(rd_beat), 2'b00});
        if (rd_beat == 0) f_cyc = cyc;
        rd_beat++;
        if (rd_beat == 4) rd_wait = -1;
      end else if (rd_wait > 0) begin
        rd_wait--;
      end else if (mem_rd_req) begin
        rd_line = mem_addr;
        fetch_addr = mem_addr;
        fetch_cnt++;
        rd_wait = RLAT;
        rd_beat = 0;
      end
      if (mem_wr_req) begin
        if (wr_wait == WLAT) begin
          mem_wr_ack = 1'b1;
          wr_wait = 0;
          wr_cnt++;
          a_cyc = cyc;
          wr_addr = mem_addr;
          wr_dat = mem_wr_data;
          wr_strb = mem_wr_strb;
          merged = rd_word(mem_addr);
          for (int b = 0; b < 4; b++)
            if (mem_wr_strb[b])
              merged[b*8 +: 8] = mem_wr_data[b*8 +: 8];
          mem[int'({mem_addr[27:2], 2'b00})] = merged;
        end else begin
          wr_wait++;
        end
      end
    end
  end

  typedef struct {
    bit          rd;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  int last_ack = 0;
  int prev_ack = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && cache_data_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {31'd0, cache_data_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.rd) check("rdata", cache_rd_data, e.d);
      end
      prev_ack = last_ack;
      last_ack = cyc;
    end
  end

  task automatic send(input bit op, input logic [27:0] a,
                      input logic [3:0] en,
                      input logic [31:0] wd,
                      input logic [31:0] exp_d,
                      output int acc);
    int n;
    exp_t e;
    e.rd = !op;
    e.d = exp_d;
    sb.push_back(e);
    cache_req = 1'b1;
    cache_op = op;
    cache_tag = a[27:12];
    cache_index = a[11:4];
    cache_offset = a[3:0];
    cache_wr_en = en;
    cache_wr_data = wd;
    #1;
    n = 0;
    while (!cache_addr_ack && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("accept_timeout", {31'd0, cache_addr_ack}, 32'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    cache_req = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  int acc, acc2, fc;

  initial begin
    rst = 1'b0;
    cache_req = 1'b0;
    cache_op = 1'b0;
    cache_tag = '0;
    cache_index = '0;
    cache_offset = '0;
    cache_wr_en = '0;
    cache_wr_data = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_addr_ack", {31'd0, cache_addr_ack}, 32'd0);
    check("rst_data_ack", {31'd0, cache_data_ack}, 32'd0);
    check("rst_rd_req", {31'd0, mem_rd_req}, 32'd0);
    check("rst_wr_req", {31'd0, mem_wr_req}, 32'd0);
    check("rst_rd_data", cache_rd_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_addr_ack", {31'd0, cache_addr_ack}, 32'd1);

    // cold read
    send(1'b0, 28'h0001234, 4'h0, 32'h0, 32'h000000A1, acc);
    drain();
    check("cold_fetch_cnt", fetch_cnt, 1);
    check("cold_fetch_addr", {4'h0, fetch_addr}, 32'h00001230);
    check("cold_latency", last_ack, f_cyc + 4);

    // two back-to-back hits
    send(1'b0, 28'h0001234, 4'h0, 32'h0, 32'h000000A1, acc);
    send(1'b0, 28'h000123C, 4'h0, 32'h0, 32'h000000A3, acc2);
    drain();
    check("hit_latency", prev_ack, acc + 1);
    check("hit_b2b", last_ack, prev_ack + 1);
    check("hit_no_fetch", fetch_cnt, 1);

    // write hit
    send(1'b1, 28'h0001234, 4'b0011, 32'hDEADBEEF, 32'h0, acc);
    drain();
    check("wh_addr", {4'h0, wr_addr}, 32'h00001234);
    check("wh_strb", {28'h0, wr_strb}, 32'h3);
    check("wh_data", wr_dat, 32'hDEADBEEF);
    check("wh_ack_time", last_ack, a_cyc + 1);
    send(1'b0, 28'h0001234, 4'h0, 32'h0, 32'h0000BEEF, acc);
    drain();
    check("wh_no_fetch", fetch_cnt, 1);

    // write miss allocates nothing
    fc = fetch_cnt;
    send(1'b1, 28'h0005670, 4'hF, 32'h11223344, 32'h0, acc);
    drain();
    check("wm_wr_cnt", wr_cnt, 2);
    check("wm_addr", {4'h0, wr_addr}, 32'h00005670);
    check("wm_no_fetch", fetch_cnt, fc);
    send(1'b0, 28'h0005670, 4'h0, 32'h0, 32'h11223344, acc);
    drain();
    check("wm_read_miss", fetch_cnt, fc + 1);

    // conflict at index 0x23
    fc = fetch_cnt;
    send(1'b0, 28'h0002234, 4'h0, 32'h0, 32'h00002234, acc);
    drain();
    check("conf_miss1", fetch_cnt, fc + 1);
    check("conf_addr", {4'h0, fetch_addr}, 32'h00002230);
    send(1'b0, 28'h0001234, 4'h0, 32'h0, 32'h0000BEEF, acc);
    drain();
    check("conf_miss2", fetch_cnt, fc + 2);

    // zero-enable write still goes to memory and acks
    send(1'b1, 28'h0001238, 4'h0, 32'hCAFEF00D, 32'h0, acc);
    drain();
    check("wz_wr_cnt", wr_cnt, 3);
    check("wz_strb", {28'h0, wr_strb}, 32'h0);
    send(1'b0, 28'h0001238, 4'h0, 32'h0, 32'h000000A2, acc);
    drain();

    // reset during beat 2 of a refill
    fc = fetch_cnt;
    send(1'b0, 28'h0004560, 4'h0, 32'h0, 32'h00004560, acc);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (!(mem_rd_valid && rd_beat == 3) && n < 100);
      check("beat2_seen", {31'd0, mem_rd_valid}, 32'd1);
    end
    rst = 1'b1;
    #1;
    sb.delete();
    check("mr_addr_ack", {31'd0, cache_addr_ack}, 32'd0);
    check("mr_data_ack", {31'd0, cache_data_ack}, 32'd0);
    check("mr_rd_req", {31'd0, mem_rd_req}, 32'd0);
    check("mr_wr_req", {31'd0, mem_wr_req}, 32'd0);
    check("mr_mem_addr", mem_addr32, 32'd0);
    check("mr_rd_data", cache_rd_data, 32'd0);
    check("mr_wr_data", mem_wr_data, 32'd0);
    check("mr_wr_strb", {28'h0, mem_wr_strb}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_release_ack", {31'd0, cache_addr_ack}, 32'd1);
    send(1'b0, 28'h0004560, 4'h0, 32'h0, 32'h00004560, acc);
    drain();
    check("mr_refetch", fetch_cnt, fc + 2);
    check("mr_fetch_addr", {4'h0, fetch_addr}, 32'h00004560);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
